tvip_mem_slave: RTL
===================

Name: tvip_mem_slave

Overview:
- Synthesizable memory responder that sits directly downstream of the tvip memory interface and consumes its we/re requests.
- Stores 256-bit words with per-byte write enables.
- Returns read data after a fixed, parameterised latency with a one-cycle rvld strobe.
- Serves as the reactive end of the 3-channel memory path in the UVM bench, and as a small on-chip RAM stand-in for the controller side.

Parameters:
- MEM_ROW_ADDR_WIDTH, 15, row address bits
- MEM_COL_ADDR_WIDTH, 10, column address bits
- MEM_BADDR_WIDTH, 3, bank address bits
- MEM_DQ_WIDTH, 32, DQ pins; word width = MEM_DQ_WIDTH*8
- CTRL_ADDR_WIDTH, MEM_ROW_ADDR_WIDTH+MEM_BADDR_WIDTH+MEM_COL_ADDR_WIDTH, request address width (28)
- ADDR_LSB, 3, address bits below word granularity (8 beats per word), ignored for indexing
- MEM_DEPTH_LOG2, 10, log2 of stored words (1024)
- RD_LAT, 2, cycles from re sample to rvld; legal range 1..8

Ports:
- aclk  input  1  clock, all logic on rising edge
- areset_n  input  1  asynchronous active-low reset
- we  input  1  write request, one word per cycle
- waddr  input  CTRL_ADDR_WIDTH  write address
- wdata  input  MEM_DQ_WIDTH*8  write data
- wb  input  MEM_DQ_WIDTH  byte enables; bit i writes wdata[8i+7:8i]
- re  input  1  read request, one word per cycle
- raddr  input  CTRL_ADDR_WIDTH  read address
- rvld  output  1  read data valid, one-cycle pulse per accepted re
- rdout  output  MEM_DQ_WIDTH*8  read data, qualified by rvld
- wr_cnt  output  32  accepted write count
- rd_cnt  output  32  accepted read count
- oor_err  output  1  sticky out-of-range flag (optional feature)

Behaviour:
- Reset: areset_n low asynchronously clears rvld=0, rdout=0, wr_cnt=0, rd_cnt=0, oor_err=0, and the read pipeline valid bits. Memory array contents are not reset; reads of never-written words return X in simulation.
- Word index = addr[ADDR_LSB+MEM_DEPTH_LOG2-1 : ADDR_LSB] for both ports.
- No backpressure; every we and every re is accepted the cycle it is high.
- Write: on an edge with we=1, bytes with wb[i]=1 update; bytes with wb[i]=0 are untouched. wb=0 still counts as an accepted write.
- Read: the array is sampled on the edge with re=1. The result travels an RD_LAT-deep valid/data shift pipeline. rvld=1 and rdout=data exactly RD_LAT cycles after the sampling edge.
- Back-to-back re every cycle gives rvld high continuously after RD_LAT, in request order.
- rdout holds its last value when rvld=0.
- Same-cycle we and re to the same word: read returns pre-write data (read-before-write). A read one cycle after a write returns the new data.
- Counters increment by 1 per accepted request and wrap 2^32-1 -> 0. Simultaneous we and re increment both.
- Reset mid-operation: in-flight reads are discarded; no rvld is produced after reset deasserts for pre-reset requests.

Optional Feature:
- Macro: TVIP_MEM_OOR_CHK_EN.
- Defined: a request whose address bits above ADDR_LSB+MEM_DEPTH_LOG2-1 are nonzero is out-of-range.
  - Write: the array write is dropped; wr_cnt still increments.
  - Read: rvld still pulses at RD_LAT with rdout=0; rd_cnt still increments.
  - oor_err sets to 1 the cycle after the offending request and stays set until reset.
- Undefined: upper address bits are ignored (addresses alias) and oor_err is tied 0.

Test Plan:
- Reset then idle 10 cycles -> rvld=0, rdout=0, wr_cnt=0, rd_cnt=0, oor_err=0 throughout.
- Write addr 0x08 data all 0xA5 wb=all-ones; then re addr 0x08 -> rvld exactly 2 cycles later, rdout all 0xA5, wr_cnt=1, rd_cnt=1.
- Write 0x10 all 0x00, then write 0x10 all 0xFF with wb=0x0000000F, read 0x10 -> rdout[31:0]=0xFFFFFFFF, remaining bytes 0x00.
- Same-cycle we and re to 0x18 (old 0x11.., new 0x22..) -> rvld returns 0x11..; next read returns 0x22...
- 16 consecutive reads of addrs 0x00..0x78 step 8 -> 16 contiguous rvld cycles, data in order; assert reset mid-burst -> rvld drops immediately and never reasserts for the remaining requests.
- With TVIP_MEM_OOR_CHK_EN defined: write to 1<<13 -> word 0 unchanged, oor_err=1 the next cycle; read of 1<<13 -> rvld with rdout=0. Without the macro: the same write aliases onto word 0.

Source files
------------

// File: rtl/tvip_mem_slave_if.sv
// Request/response bundle between the tvip memory interface and its RAM responder.
interface tvip_mem_slave_if #(
    parameter int CTRL_ADDR_WIDTH = 28,
    parameter int MEM_DQ_WIDTH    = 32
);
    logic                         we;
    logic [CTRL_ADDR_WIDTH-1:0]   waddr;
    logic [MEM_DQ_WIDTH*8-1:0]    wdata;
    logic [MEM_DQ_WIDTH-1:0]      wb;
    logic                         re;
    logic [CTRL_ADDR_WIDTH-1:0]   raddr;
    logic                         rvld;
    logic [MEM_DQ_WIDTH*8-1:0]    rdout;
    logic [31:0]                  wr_cnt;
    logic [31:0]                  rd_cnt;
    logic                         oor_err;

    modport master (
        output we, waddr, wdata, wb, re, raddr,
        input  rvld, rdout, wr_cnt, rd_cnt, oor_err
    );

    modport slave (
        input  we, waddr, wdata, wb, re, raddr,
        output rvld, rdout, wr_cnt, rd_cnt, oor_err
    );
endinterface

// File: rtl/tvip_mem_slave.sv
// Byte-enabled 256-bit word RAM responder with fixed read latency.
// Optional address range checking is enabled by defining TVIP_MEM_OOR_CHK_EN.
module tvip_mem_slave #(
    parameter int MEM_ROW_ADDR_WIDTH = 15,
    parameter int MEM_COL_ADDR_WIDTH = 10,
    parameter int MEM_BADDR_WIDTH    = 3,
    parameter int MEM_DQ_WIDTH       = 32,
    parameter int CTRL_ADDR_WIDTH    = MEM_ROW_ADDR_WIDTH + MEM_BADDR_WIDTH
                                       + MEM_COL_ADDR_WIDTH,
    parameter int ADDR_LSB           = 3,
    parameter int MEM_DEPTH_LOG2     = 10,
    parameter int RD_LAT             = 2
) (
    input  logic              aclk,
    input  logic              areset_n,
    tvip_mem_slave_if.slave   mem
);
    localparam int W     = MEM_DQ_WIDTH * 8;
    localparam int DEPTH = 1 << MEM_DEPTH_LOG2;
    localparam int HI    = ADDR_LSB + MEM_DEPTH_LOG2;

    logic [W-1:0]              r_mem [DEPTH];
    logic [RD_LAT-1:0]         r_pv;
    logic [W-1:0]              r_pd [RD_LAT];
    logic                      r_rvld;
    logic [W-1:0]              r_rdout;
    logic [31:0]               r_wr_cnt;
    logic [31:0]               r_rd_cnt;

    logic [MEM_DEPTH_LOG2-1:0] w_widx;
    logic [MEM_DEPTH_LOG2-1:0] w_ridx;
    logic                      w_woor;
    logic                      w_roor;
    logic                      w_wr;
    logic [W-1:0]              w_rdat;
    logic                      w_unused;

    assign w_widx   = mem.waddr[HI-1:ADDR_LSB];
    assign w_ridx   = mem.raddr[HI-1:ADDR_LSB];
    assign w_unused = ^{mem.waddr, mem.raddr};

`ifdef TVIP_MEM_OOR_CHK_EN
    logic r_oor;

    assign w_woor = |mem.waddr[CTRL_ADDR_WIDTH-1:HI];
    assign w_roor = |mem.raddr[CTRL_ADDR_WIDTH-1:HI];

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            r_oor <= 1'b0;
        end else if ((mem.we && w_woor) || (mem.re && w_roor)) begin
            r_oor <= 1'b1;
        end
    end

    assign mem.oor_err = r_oor;
`else
    assign w_woor      = 1'b0;
    assign w_roor      = 1'b0;
    assign mem.oor_err = 1'b0;
`endif

    assign w_wr   = mem.we && !w_woor;
    assign w_rdat = w_roor ? '0 : r_mem[w_ridx];

    // Array is not reset; unwritten words read back as X.
    always_ff @(posedge aclk) begin
        if (w_wr) begin
            for (int i = 0; i < MEM_DQ_WIDTH; i++) begin
                if (mem.wb[i]) begin
                    r_mem[w_widx][8*i +: 8] <= mem.wdata[8*i +: 8];
                end
            end
        end
    end

    // Stage 0 captures pre-write data, giving read-before-write on collisions.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            r_pv    <= '0;
            r_rvld  <= 1'b0;
            r_rdout <= '0;
            for (int k = 0; k < RD_LAT; k++) begin
                r_pd[k] <= '0;
            end
        end else begin
            r_pv[0] <= mem.re;
            if (mem.re) begin
                r_pd[0] <= w_rdat;
            end
            for (int k = 1; k < RD_LAT; k++) begin
                r_pv[k] <= r_pv[k-1];
                r_pd[k] <= r_pd[k-1];
            end
            r_rvld <= r_pv[RD_LAT-1];
            if (r_pv[RD_LAT-1]) begin
                r_rdout <= r_pd[RD_LAT-1];
            end
        end
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            r_wr_cnt <= '0;
            r_rd_cnt <= '0;
        end else begin
            if (mem.we) begin
                r_wr_cnt <= r_wr_cnt + 32'd1;
            end
            if (mem.re) begin
                r_rd_cnt <= r_rd_cnt + 32'd1;
            end
        end
    end

    assign mem.rvld   = r_rvld;
    assign mem.rdout  = r_rdout;
    assign mem.wr_cnt = r_wr_cnt;
    assign mem.rd_cnt = r_rd_cnt;
endmodule
